resonant_sys: RTL and testbench
===============================

Name: resonant_sys

Overview:
- Behavioural emulation of the resonant front-end's charge-delivery system.
- On a start request it latches a reference charge `i_ref`. It then delivers that charge as a serial train of fixed-width pulses on `q_serialized`; each pulse represents `Q_PER_PULSE` charge units.
- It flags `pulses_ended` once the latched charge is exhausted.
- Sits between the reference/control logic and the serial charge consumer (counter/integrator) of the front-end.

Parameters:
- `BUS_WIDTH`, 10, width of `i_ref` and of the residual-charge register.
- `PULSE_DURATION`, 3, clock cycles `q_serialized` stays high per pulse; the gap after each pulse is the same number of low cycles. Must be ≥ 1.
- `Q_PER_PULSE`, 60, charge units removed per pulse. Must be in 1..2^BUS_WIDTH−1.

Ports:
- `clk`, input, 1, system clock; all state updates on the rising edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `i_ref`, input, BUS_WIDTH, reference charge (unsigned). Sampled only on a start event.
- `start`, input, 1, run request, synchronous to `clk`. A rising edge starts a burst; holding it low aborts or re-arms.
- `q_serialized`, output, 1, serial charge pulse train (registered).
- `pulses_ended`, output, 1, high while the burst has completed and `start` is still held high (registered).

Behaviour:
- Reset (`rst_n` = 0, asynchronous):
  - state = IDLE, residual R = 0, cycle counter = 0, `start_d` = 0.
  - `q_serialized` = 0, `pulses_ended` = 0.
- Start detection: `start_d` registers `start`. A start event is `start` = 1 and `start_d` = 0, sampled in IDLE.
- States: IDLE, PULSE, GAP, DONE.
- IDLE, on a start event:
  - R ← `i_ref`, counter ← 0.
  - Next state is PULSE if `i_ref` ≠ 0, else DONE.
- PULSE:
  - `q_serialized` = 1 for exactly `PULSE_DURATION` cycles.
  - On the last cycle: R ← (R > `Q_PER_PULSE`) ? R − `Q_PER_PULSE` : 0 (saturating), counter ← 0, next state GAP.
- GAP:
  - `q_serialized` = 0 for `PULSE_DURATION` cycles.
  - On the last cycle, next state is DONE if R = 0, else PULSE.
- DONE:
  - `pulses_ended` = 1, `q_serialized` = 0.
  - Stays in DONE while `start` = 1; goes to IDLE when `start` = 0.
- Outputs are registered decodes of the next state:
  - `q_serialized` rises on the clock edge that sampled the start event.
  - `pulses_ended` rises on the edge that leaves the final GAP.
- Pulse count per burst = ceil(`i_ref` / `Q_PER_PULSE`). Burst length from start event to `pulses_ended` = 2·`PULSE_DURATION`·count cycles.
- Abort: `start` = 0 in PULSE, GAP or DONE → next cycle IDLE, `q_serialized` = 0, `pulses_ended` = 0, R cleared. No partial-pulse completion.
- Retrigger:
  - A new burst requires `start` to be seen low in IDLE, then high.
  - Holding `start` high after DONE never restarts a burst.
- `i_ref` changes outside a start event are ignored; the latched R is used for the whole burst.
- `i_ref` = 0 → no pulses. `pulses_ended` goes high one cycle after the start event.
- `i_ref` an exact multiple of `Q_PER_PULSE` → no extra pulse. Any remainder produces one final full-width pulse.
- Reset mid-burst: immediate return to the reset values above, including `q_serialized` forced low asynchronously.

Test Plan:
- Reset: assert `rst_n` = 0 mid-pulse → `q_serialized` = 0, `pulses_ended` = 0 immediately; after release with `start` = 0, both outputs stay 0.
- Nominal burst: `i_ref` = 600, `start` 0→1 → exactly 10 pulses, each 3 cycles high and 3 low. `pulses_ended` = 1 after 60 cycles and held while `start` = 1.
- Latching: `i_ref` = 600 at start, changed to 1000 mid-burst → still 10 pulses. Then `start` 1→0→1 with `i_ref` = 1000 → 17 pulses (ceil 1000/60), `pulses_ended` after 102 cycles.
- Abort: `start` dropped during the 4th pulse → `q_serialized` low next cycle. `pulses_ended` never asserts; the next rising `start` begins a fresh full burst.
- Boundary: `i_ref` = 0 → no pulses, `pulses_ended` = 1 one cycle after start. `i_ref` = 120 → exactly 2 pulses. `i_ref` = 61 → 2 pulses. `i_ref` = 1023 → 18 pulses.
- No retrigger: hold `start` high for 200 cycles after DONE → no further pulses, `pulses_ended` stays 1.

Source files
------------

// File: rtl/resonant_sys.sv
// Purpose: serialises a latched reference charge into fixed-width pulses, flagging when it is exhausted.
// Latency: first pulse is high on the edge that samples the start event; outputs are registered.
// Backpressure: none; the consumer must accept every pulse, and dropping start aborts the burst at once.
module resonant_sys #(
    parameter int BUS_WIDTH      = 10,
    parameter int PULSE_DURATION = 3,
    parameter int Q_PER_PULSE    = 60
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] i_ref,
    input  logic                 start,
    output logic                 q_serialized,
    output logic                 pulses_ended
);

    // Counter only needs to reach PULSE_DURATION-1; keep at least one bit.
    localparam int CW = (PULSE_DURATION > 1) ? $clog2(PULSE_DURATION) : 1;
    localparam logic [CW-1:0]        CNT_LAST = CW'(PULSE_DURATION - 1);
    localparam logic [BUS_WIDTH-1:0] QPP      = BUS_WIDTH'(Q_PER_PULSE);

    typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;

    state_t               state, state_nxt;
    logic [BUS_WIDTH-1:0] resid, resid_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 start_d;
    logic                 start_evt;
    logic                 cnt_last;
    logic                 q_nxt;
    logic                 pe_nxt;

    assign start_evt = start & ~start_d;
    assign cnt_last  = (cnt == CNT_LAST);

    // State, datapath and registered outputs; reset also forces the pulse line low asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            resid        <= '0;
            cnt          <= '0;
            start_d      <= 1'b0;
            q_serialized <= 1'b0;
            pulses_ended <= 1'b0;
        end else begin
            state        <= state_nxt;
            resid        <= resid_nxt;
            cnt          <= cnt_nxt;
            start_d      <= start;
            q_serialized <= q_nxt;
            pulses_ended <= pe_nxt;
        end
    end

    // Next-state logic: dropping start in any active state aborts with no partial-pulse completion.
    always_comb begin
        state_nxt = state;
        resid_nxt = resid;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start_evt) begin
                    resid_nxt = i_ref;
                    cnt_nxt   = '0;
                    state_nxt = (i_ref != '0) ? PULSE : DONE;
                end
            end
            PULSE: begin
                if (!start) begin
                    state_nxt = IDLE;
                    resid_nxt = '0;
                    cnt_nxt   = '0;
                end else if (cnt_last) begin
                    // Saturate so a partial remainder still costs one full pulse.
                    resid_nxt = (resid > QPP) ? (resid - QPP) : '0;
                    cnt_nxt   = '0;
                    state_nxt = GAP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            GAP: begin
                if (!start) begin
                    state_nxt = IDLE;
                    resid_nxt = '0;
                    cnt_nxt   = '0;
                end else if (cnt_last) begin
                    cnt_nxt   = '0;
                    state_nxt = (resid == '0) ? DONE : PULSE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                // Holding start high parks here; only a low start re-arms via IDLE.
                if (!start) begin
                    state_nxt = IDLE;
                    resid_nxt = '0;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                resid_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode of the next state, so outputs line up with the state they describe.
    always_comb begin
        q_nxt  = (state_nxt == PULSE);
        pe_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_resonant_sys.sv
module tb_resonant_sys;

    localparam int BW  = 10;
    localparam int PD  = 3;
    localparam int QPP = 60;

    logic          clk;
    logic          rst_n;
    logic [BW-1:0] i_ref;
    logic          start;
    logic          q_serialized;
    logic          pulses_ended;

    int n_cmp = 0;
    int n_bad = 0;

    resonant_sys #(
        .BUS_WIDTH     (BW),
        .PULSE_DURATION(PD),
        .Q_PER_PULSE   (QPP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ref       (i_ref),
        .start       (start),
        .q_serialized(q_serialized),
        .pulses_ended(pulses_ended)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Burst-level model: a burst is a start event followed by ceil(ref/QPP)
    // pulses of PD high + PD low cycles, then a done flag until start drops.
    bit m_busy;
    bit m_prev;
    int m_k;
    int m_n;

    initial begin
        m_busy = 0;
        m_prev = 0;
        m_k    = 0;
        m_n    = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_busy = 0;
                m_prev = 0;
            end else begin
                if (m_busy && !start) begin
                    m_busy = 0;
                end else if (!m_busy && start && !m_prev) begin
                    m_busy = 1;
                    m_k    = 0;
                    m_n    = (int'(i_ref) + QPP - 1) / QPP;
                end else if (m_busy) begin
                    m_k++;
                end
                m_prev = start;
                #1;
                if (rst_n) begin
                    check("model_q", int'(q_serialized),
                          int'(m_busy && m_k < 2*PD*m_n && (m_k % (2*PD)) < PD));
                    check("model_pe", int'(pulses_ended),
                          int'(m_busy && m_k >= 2*PD*m_n));
                end
            end
        end
    end

    // Raise start, count pulses until pulses_ended, compare with literals.
    task automatic run_burst(input string nm, input int iref, input int exp_pulses,
                             input int change_at, input int new_iref);
        int  pulses;
        int  len;
        bit  prevq;
        @(negedge clk);
        i_ref = BW'(iref);
        start = 1'b1;
        pulses = 0;
        len    = -1;
        prevq  = 0;
        for (int e = 0; e < 2*PD*exp_pulses + 20; e++) begin
            @(posedge clk);
            #2;
            if (e == change_at) i_ref = BW'(new_iref);
            if (q_serialized && !prevq) pulses++;
            prevq = q_serialized;
            if (pulses_ended) begin
                len = e;
                break;
            end
        end
        check({nm, "_pulses"}, pulses, exp_pulses);
        check({nm, "_len"}, len, 2*PD*exp_pulses);
    endtask

    task automatic drop_start(input string nm);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check({nm, "_idle_q"}, int'(q_serialized), 0);
        check({nm, "_idle_pe"}, int'(pulses_ended), 0);
    endtask

    // Hold start high after DONE: no new pulses, done flag stays up.
    task automatic hold_done(input int cycles);
        int rises;
        int pe_low;
        bit prevq;
        rises  = 0;
        pe_low = 0;
        prevq  = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #2;
            if (q_serialized && !prevq) rises++;
            prevq = q_serialized;
            if (!pulses_ended) pe_low++;
        end
        check("hold_pulses", rises, 0);
        check("hold_pe_low_cycles", pe_low, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pe_seen;
        rst_n = 1'b0;
        start = 1'b0;
        i_ref = '0;
        #1;
        check("reset_q", int'(q_serialized), 0);
        check("reset_pe", int'(pulses_ended), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("post_reset_q", int'(q_serialized), 0);
        check("post_reset_pe", int'(pulses_ended), 0);

        // Nominal burst, then held done
        run_burst("nominal600", 600, 10, -1, 0);
        hold_done(10);
        drop_start("nominal600");

        // Latching: ref changes mid-burst are ignored
        run_burst("latch600", 600, 10, 20, 1000);
        drop_start("latch600");
        run_burst("ref1000", 1000, 17, -1, 0);
        drop_start("ref1000");

        // Abort during the 4th pulse (high after edges 18..20)
        @(negedge clk);
        i_ref = BW'(600);
        start = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        check("abort_in_pulse_q", int'(q_serialized), 1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        check("abort_q_low", int'(q_serialized), 0);
        pe_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #2;
            if (pulses_ended) pe_seen++;
        end
        check("abort_pe_never", pe_seen, 0);
        run_burst("after_abort", 600, 10, -1, 0);
        drop_start("after_abort");

        // Boundaries
        run_burst("ref0", 0, 0, -1, 0);
        drop_start("ref0");
        run_burst("ref120", 120, 2, -1, 0);
        drop_start("ref120");
        run_burst("ref61", 61, 2, -1, 0);
        drop_start("ref61");
        run_burst("ref1023", 1023, 18, -1, 0);

        // No retrigger while start stays high
        hold_done(200);
        drop_start("ref1023");

        // Reset mid-pulse
        @(negedge clk);
        i_ref = BW'(600);
        start = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        check("pre_reset_q", int'(q_serialized), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_q", int'(q_serialized), 0);
        check("midreset_pe", int'(pulses_ended), 0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("after_midreset_q", int'(q_serialized), 0);
        check("after_midreset_pe", int'(pulses_ended), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
